otter_uart_tx: RTL and testbench
================================

// Module: otter_uart_tx
// PURPOSE
//  Memory-mapped UART transmitter; a responder on the system bus alongside sram.
//  The core writes bytes into a TX FIFO; a frame engine serialises them 8N1, LSB first.
//  The status register lets software poll FIFO level and overflow.
//  Claims a 16-byte window; addresses outside it are left to other responders.
// PARAMETERS
//  BASE_ADDR  32'h1100_0000  window base; decode is bus_addr[31:4]==BASE_ADDR[31:4]
//  FIFO_DEPTH 8              TX FIFO entries, power of two, >=2
//  DIV_RESET  16'd868        reset clocks-per-bit (100 MHz / 115200)
// PORTS
//  clk        in   1   system clock
//  rst        in   1   synchronous, active-low reset
//  bus_req    in   1   request valid; held until bus_ack
//  bus_we     in   1   1=write, 0=read
//  bus_addr   in   32  byte address
//  bus_wdata  in   32  write data
//  bus_be     in   4   byte enables for writes
//  bus_rdata  out  32  read data, valid with bus_ack
//  bus_ack    out  1   one-cycle completion pulse
//  uart_tx    out  1   serial output, idle high
// BEHAVIOUR
//  Reset (rst==0 at posedge):
//  - bus_ack=0, bus_rdata=0, uart_tx=1, FIFO empty, ovf=0, div=DIV_RESET, FSM=IDLE.
//  - A frame in progress is aborted; uart_tx is high after that edge.
//  Bus handshake:
//  - bus_req in window, bus_ack low -> bus_ack=1 the next cycle, for exactly 1 cycle.
//  - The cycle after an ack is never acked. At most one outstanding access.
//  - Write side effects occur on the ack edge. bus_rdata is 0 whenever bus_ack=0.
//  Register map (offset = bus_addr[3:0]):
//  - 0x0 TXDATA: a write with be[0] pushes wdata[7:0]; reads return 0.
//  - 0x4 STATUS (read):
//    - [0] busy (FSM!=IDLE or FIFO not empty), [1] full, [2] empty, [3] ovf.
//    - [15:8] FIFO count. All other bits 0.
//  - 0x4 STATUS (write): be[0] && wdata[3] clears ovf. Other bits are ignored.
//  - 0x8 BAUDDIV: RW [15:0]; be[0] writes [7:0], be[1] writes [15:8]; reads zero-extended.
//  - 0xC and any unaligned offset: ack, rdata=0, write ignored.
//  FIFO:
//  - Push to a full FIFO is dropped and sets ovf.
//  - Push and pop in the same cycle while full: both succeed, count unchanged, ovf stays 0.
//  - Push and pop in the same cycle while empty is impossible; the pop sees the pre-push state.
//  - Pointers wrap modulo FIFO_DEPTH; count is $clog2(FIFO_DEPTH)+1 bits.
//  TX FSM (IDLE -> START -> DATA -> STOP -> IDLE|START):
//  - Bit period P = div, with div==0 treated as 1. div is latched into a shadow at each frame start.
//  - IDLE, FIFO not empty:
//    - Pop into the shift register; START begins next cycle.
//    - Pop-to-start-bit latency is 1 clk.
//  - START: uart_tx=0 for P clks.
//  - DATA: 8 bits LSB first, P clks each, with a 3-bit bit counter.
//  - STOP: uart_tx=1 for P clks.
//    - If FIFO not empty at the end of STOP, pop and go directly to START (no idle gap).
//    - Otherwise go to IDLE.
//  - Frame length is exactly 10*P clks.
//  - A div write mid-frame does not affect the current frame.
// TESTING
//  - Reset hold 3 clks, then read 0x4:
//    - Expect rdata=0x0000_0004, uart_tx=1.
//    - Read 0x8 -> 868.
//  - div=4, write 0x55 to 0x0:
//    - uart_tx = 0,1,0,1,0,1,0,1,0,1 (start..stop), each bit 4 clks, total 40 clks.
//  - div=2, write 0xA1, 0x3C back-to-back:
//    - Two frames, no idle between the stop bit and the second start bit.
//    - STATUS busy=1 until done.
//  - div=100, write 10 bytes:
//    - 1 popped to the engine, 8 fill the FIFO.
//    - Byte 10 is dropped and STATUS reads 0x0000_080B (count 8, full, ovf, busy).
//    - Write 0x8 to 0x4 -> ovf=0.
//  - Access 0x1100_0010: no ack.
//  - Read 0x1100_000C: ack, rdata=0.
//  - Write 0x8 with be=4'b0001 data 0x1234 -> div low byte only becomes 0x34.
//  - Assert rst low mid-DATA:
//    - uart_tx=1 the next clk, FIFO empty.
//    - After release, a new write transmits correctly.

Source files
------------

// File: rtl/otter_uart_tx_if.sv
// System bus responder port bundle for the UART transmitter.
// Handshake: master raises bus_req with stable we/addr/wdata/be and holds it until it sees bus_ack;
// the slave answers with a single-cycle bus_ack, bus_rdata is valid only while bus_ack=1 and is 0 otherwise.
interface otter_uart_tx_if;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_be;
  logic [31:0] bus_rdata;
  logic        bus_ack;

  modport master (
    output bus_req, bus_we, bus_addr, bus_wdata, bus_be,
    input  bus_rdata, bus_ack
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_wdata, bus_be,
    output bus_rdata, bus_ack
  );
endinterface

// File: rtl/otter_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: bus register file, TX FIFO and a frame engine.
// The engine state is exported on dbg_state (0 idle, 1 start, 2 data, 3 stop).
module otter_uart_tx #(
  parameter logic [31:0] BASE_ADDR  = 32'h1100_0000,
  parameter int          FIFO_DEPTH = 8,
  parameter logic [15:0] DIV_RESET  = 16'd868
) (
  input  logic             clk,
  input  logic             rst,
  otter_uart_tx_if.slave   bus,
  output logic             uart_tx,
  output logic [1:0]       dbg_state
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } tx_state_t;

  // ---------------- bus decode ----------------
  logic        ack_q;
  logic [31:0] rdata_q;
  logic        sel;
  logic [3:0]  off;
  logic        wr;
  logic        push;
  logic        wr_ovf_clr;
  logic        wr_div_lo;
  logic        wr_div_hi;
  logic [31:0] rd_mux;
  logic [31:0] status;

  // A new access is never accepted while ack is high, so back-to-back acks cannot occur.
  assign sel        = bus.bus_req && (bus.bus_addr[31:4] == BASE_ADDR[31:4]) && !ack_q;
  assign off        = bus.bus_addr[3:0];
  assign wr         = sel && bus.bus_we;
  assign push       = wr && (off == 4'h0) && bus.bus_be[0];
  assign wr_ovf_clr = wr && (off == 4'h4) && bus.bus_be[0] && bus.bus_wdata[3];
  assign wr_div_lo  = wr && (off == 4'h8) && bus.bus_be[0];
  assign wr_div_hi  = wr && (off == 4'h8) && bus.bus_be[1];

  assign bus.bus_ack   = ack_q;
  assign bus.bus_rdata = rdata_q;

  logic unused_bus_bits;
  assign unused_bus_bits = ^{bus.bus_wdata[31:16], bus.bus_be[3:2]};

  // ---------------- registers ----------------
  logic [15:0] div;
  logic        ovf;

  // ---------------- FIFO ----------------
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [CW-1:0] count;
  logic          full;
  logic          empty;
  logic          pop;
  logic          push_ok;
  logic [7:0]    cnt8;

  assign full    = (count == CW'(FIFO_DEPTH));
  assign empty   = (count == '0);
  // When full, a simultaneous pop frees the slot the push lands in.
  assign push_ok = push && (!full || pop);
  assign cnt8    = 8'(count);

  // ---------------- frame engine ----------------
  tx_state_t   state;
  tx_state_t   state_n;
  logic [7:0]  shift;
  logic [7:0]  shift_n;
  logic [2:0]  bit_cnt;
  logic [15:0] clk_cnt;
  logic [15:0] shadow;
  logic [15:0] period_m1;
  logic        bit_end;
  logic        load;
  logic        tx_d;
  logic        tx_q;
  logic        busy;

  assign busy      = (state != S_IDLE) || !empty;
  assign status    = {16'h0000, cnt8, 4'h0, ovf, empty, full, busy};
  assign period_m1 = (shadow == 16'd0) ? 16'd0 : (shadow - 16'd1);
  assign bit_end   = (clk_cnt == period_m1);
  assign uart_tx   = tx_q;
  assign dbg_state = state;

  always_comb begin
    rd_mux = '0;
    case (off)
      4'h4:    rd_mux = status;
      4'h8:    rd_mux = {16'h0000, div};
      default: rd_mux = '0;
    endcase
  end

  always_comb begin
    state_n = state;
    pop     = 1'b0;
    load    = 1'b0;
    case (state)
      S_IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          load    = 1'b1;
          state_n = S_START;
        end
      end
      S_START: begin
        if (bit_end) state_n = S_DATA;
      end
      S_DATA: begin
        if (bit_end && (bit_cnt == 3'd7)) state_n = S_STOP;
      end
      S_STOP: begin
        // Chain straight into the next start bit when more data is waiting.
        if (bit_end) begin
          if (!empty) begin
            pop     = 1'b1;
            load    = 1'b1;
            state_n = S_START;
          end else begin
            state_n = S_IDLE;
          end
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_comb begin
    shift_n = shift;
    if (load) begin
      shift_n = mem[rptr];
    end else if ((state == S_DATA) && bit_end) begin
      shift_n = {1'b0, shift[7:1]};
    end
    case (state_n)
      S_START: tx_d = 1'b0;
      S_DATA:  tx_d = shift_n[0];
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      ack_q   <= 1'b0;
      rdata_q <= '0;
      div     <= DIV_RESET;
      ovf     <= 1'b0;
      wptr    <= '0;
      rptr    <= '0;
      count   <= '0;
    end else begin
      ack_q   <= sel;
      rdata_q <= (sel && !bus.bus_we) ? rd_mux : '0;
      if (wr_div_lo) div[7:0]  <= bus.bus_wdata[7:0];
      if (wr_div_hi) div[15:8] <= bus.bus_wdata[15:8];
      if (wr_ovf_clr) begin
        ovf <= 1'b0;
      end else if (push && !push_ok) begin
        ovf <= 1'b1;
      end
      if (push_ok) wptr <= wptr + 1'b1;
      if (pop)     rptr <= rptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wptr] <= bus.bus_wdata[7:0];
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= S_IDLE;
      shift   <= '0;
      bit_cnt <= '0;
      clk_cnt <= '0;
      shadow  <= DIV_RESET;
      tx_q    <= 1'b1;
    end else begin
      state <= state_n;
      shift <= shift_n;
      tx_q  <= tx_d;
      // The bit period is frozen for the whole frame at the moment the byte is popped.
      if (load) shadow <= div;
      if (load || bit_end || (state_n == S_IDLE)) begin
        clk_cnt <= '0;
      end else begin
        clk_cnt <= clk_cnt + 16'd1;
      end
      if (state == S_START) begin
        bit_cnt <= '0;
      end else if ((state == S_DATA) && bit_end) begin
        bit_cnt <= bit_cnt + 3'd1;
      end
    end
  end

endmodule

// File: tb/tb_otter_uart_tx.sv
// Directed bench for otter_uart_tx: register access, serial framing, FIFO overflow and reset abort.
module tb_otter_uart_tx;

  localparam logic [31:0] BASE = 32'h1100_0000;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  otter_uart_tx_if bus_if ();
  logic       uart_tx;
  logic [1:0] dbg_state;

  otter_uart_tx #(
    .BASE_ADDR (BASE),
    .FIFO_DEPTH(8),
    .DIV_RESET (16'd868)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus_if),
    .uart_tx  (uart_tx),
    .dbg_state(dbg_state)
  );

  // ---------------- scoreboard ----------------
  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic bus_access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [3:0] be, output logic [31:0] rdata, output logic acked);
    @(negedge clk);
    bus_if.bus_req   = 1'b1;
    bus_if.bus_we    = we;
    bus_if.bus_addr  = addr;
    bus_if.bus_wdata = wdata;
    bus_if.bus_be    = be;
    acked = 1'b0;
    rdata = '0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      if (bus_if.bus_ack === 1'b1) begin
        acked = 1'b1;
        rdata = bus_if.bus_rdata;
        break;
      end
    end
    bus_if.bus_req = 1'b0;
    bus_if.bus_we  = 1'b0;
  endtask

  task automatic bus_write(input string tag, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] be);
    logic [31:0] rd;
    logic        ack;
    bus_access(1'b1, addr, wdata, be, rd, ack);
    check_eq({tag, "_ack"}, 32'(ack), 32'd1);
  endtask

  task automatic bus_read(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    logic [31:0] rd;
    logic        ack;
    bus_access(1'b0, addr, 32'h0, 4'h0, rd, ack);
    check_eq({tag, "_ack"}, 32'(ack), 32'd1);
    check_eq(tag, rd, exp);
  endtask

  task automatic send_byte(input logic [7:0] b);
    exp_q.push_back(b);
    bus_write($sformatf("tx_%02h", b), BASE, {24'h0, b}, 4'b0001);
  endtask

  // Waits for a start bit, then checks n contiguous frames of 10*p clocks against exp_q.
  task automatic check_frames(input int n, input int p);
    int waited = 0;
    while ((uart_tx === 1'b1) && (waited < 20 * p + 50)) begin
      @(posedge clk);
      #1;
      waited++;
    end
    if (uart_tx !== 1'b0) begin
      check_eq("start_bit_timeout", 32'(uart_tx), 32'd0);
      return;
    end
    for (int f = 0; f < n; f++) begin
      logic [7:0] b;
      logic [9:0] fr;
      check_eq($sformatf("frame%0d_queued", f), 32'(exp_q.size() > 0), 32'd1);
      b  = (exp_q.size() > 0) ? exp_q.pop_front() : 8'h00;
      fr = {1'b1, b, 1'b0};
      for (int k = 0; k < 10; k++) begin
        int match = 0;
        for (int c = 0; c < p; c++) begin
          if (uart_tx === fr[k]) match++;
          @(posedge clk);
          #1;
        end
        check_eq($sformatf("frame%0d_bit%0d", f, k), 32'(match), 32'(p));
      end
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] rd;
    logic        ack;
    int          waited;
    bus_if.bus_req   = 1'b0;
    bus_if.bus_we    = 1'b0;
    bus_if.bus_addr  = '0;
    bus_if.bus_wdata = '0;
    bus_if.bus_be    = '0;

    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_uart_tx", 32'(uart_tx), 32'd1);
    check_eq("rst_ack", 32'(bus_if.bus_ack), 32'd0);
    check_eq("rst_rdata", bus_if.bus_rdata, 32'h0);
    check_eq("rst_state", 32'(dbg_state), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    bus_read("status_reset", BASE + 32'h4, 32'h0000_0004);
    bus_read("div_reset", BASE + 32'h8, 32'd868);
    bus_read("txdata_reads_zero", BASE + 32'h0, 32'h0);
    check_eq("rdata_idle_zero", bus_if.bus_rdata, 32'h0);

    // Single frame, P=4: 0,1,0,1,0,1,0,1,0,1 over 40 clocks.
    bus_write("div4", BASE + 32'h8, 32'd4, 4'b0011);
    send_byte(8'h55);
    check_frames(1, 4);
    check_eq("idle_after_55", 32'(dbg_state), 32'd0);
    check_eq("line_high_after_55", 32'(uart_tx), 32'd1);

    // Two queued bytes at P=2 must chain with no idle gap.
    bus_write("div2", BASE + 32'h8, 32'd2, 4'b0011);
    fork
      begin
        send_byte(8'hA1);
        send_byte(8'h3C);
        bus_read("status_mid_burst", BASE + 32'h4, 32'h0000_0101);
      end
      begin
        check_frames(2, 2);
      end
    join
    bus_read("status_after_burst", BASE + 32'h4, 32'h0000_0004);

    // Overflow: one byte in flight, eight queued, tenth dropped.
    bus_write("div100", BASE + 32'h8, 32'd100, 4'b0011);
    for (int i = 0; i < 10; i++) begin
      bus_write($sformatf("ovf_push%0d", i), BASE, 32'(8'h10 + i), 4'b0001);
    end
    bus_read("status_overflow", BASE + 32'h4, 32'h0000_080B);
    bus_write("ovf_clear", BASE + 32'h4, 32'h8, 4'b0001);
    bus_read("status_ovf_cleared", BASE + 32'h4, 32'h0000_0803);

    // Abort a frame mid-DATA with reset.
    waited = 0;
    while ((dbg_state !== 2'd2) && (waited < 400)) begin
      @(posedge clk);
      #1;
      waited++;
    end
    check_eq("reached_data", 32'(dbg_state), 32'd2);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check_eq("abort_uart_tx", 32'(uart_tx), 32'd1);
    check_eq("abort_state", 32'(dbg_state), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    bus_read("status_after_abort", BASE + 32'h4, 32'h0000_0004);
    bus_read("div_after_abort", BASE + 32'h8, 32'd868);

    // Address decode edges.
    bus_access(1'b0, BASE + 32'h10, 32'h0, 4'h0, rd, ack);
    check_eq("out_of_window_ack", 32'(ack), 32'd0);
    bus_read("reserved_0c", BASE + 32'hC, 32'h0);
    bus_read("unaligned_09", BASE + 32'h9, 32'h0);
    bus_write("unaligned_wr", BASE + 32'h9, 32'h0000_FFFF, 4'b0011);
    bus_read("div_after_unaligned", BASE + 32'h8, 32'd868);

    // Partial byte-enable write: 0x0364 -> 0x0334.
    bus_write("div_lo_only", BASE + 32'h8, 32'h0000_1234, 4'b0001);
    bus_read("div_lo_result", BASE + 32'h8, 32'h0000_0334);

    // Engine recovers after reset.
    bus_write("div3", BASE + 32'h8, 32'd3, 4'b0011);
    send_byte(8'hC3);
    check_frames(1, 3);
    check_eq("idle_after_c3", 32'(dbg_state), 32'd0);
    check_eq("exp_q_drained", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
